// File: rtl/word_serializer.sv
// Word-to-symbol serializer: takes one DW-bit word per reader handshake and streams it as
// DW/BW symbols on a valid/ready port. Define WORD_SERIALIZER_MSB_FIRST_EN for MSB-first order.
module word_serializer #(
  parameter int unsigned DW = 64,
  parameter int unsigned BW = 8,
  parameter int unsigned CW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] word,
  input  logic          word_valid,
  output logic          word_writed,
  output logic [BW-1:0] sym_data,
  output logic          sym_valid,
  input  logic          sym_ready,
  output logic          busy,
  output logic [CW-1:0] word_count
);

  localparam int unsigned NSYM = DW / BW;
  localparam int unsigned SCW  = $clog2(NSYM) + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StShift = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] shreg_q, shreg_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic          sym_valid_q, sym_valid_d;
  logic [BW-1:0] sym_data_q, sym_data_d;
  logic          word_writed_q, word_writed_d;
  logic [CW-1:0] word_count_q, word_count_d;
  logic          busy_q, busy_d;

  // Symbol order is the only difference between the two builds.
  logic [DW-1:0] shreg_next;
  logic [BW-1:0] word_head;
  logic [BW-1:0] next_head;

`ifdef WORD_SERIALIZER_MSB_FIRST_EN
  assign shreg_next = shreg_q << BW;
  assign word_head  = word[DW-1 -: BW];
  assign next_head  = shreg_next[DW-1 -: BW];
`else
  assign shreg_next = shreg_q >> BW;
  assign word_head  = word[BW-1:0];
  assign next_head  = shreg_next[BW-1:0];
`endif

  logic sym_fire;
  assign sym_fire = sym_valid_q && sym_ready;

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    sym_valid_d   = sym_valid_q;
    sym_data_d    = sym_data_q;
    word_writed_d = 1'b0;
    word_count_d  = word_count_q;

    unique case (state_q)
      StIdle: begin
        sym_valid_d = 1'b0;
        if (start) begin
          state_d      = StLoad;
          word_count_d = '0;
        end
      end

      StLoad: begin
        if (!start) begin
          state_d = StIdle;
        end else if (word_valid) begin
          shreg_d       = word;
          cnt_d         = SCW'(NSYM);
          word_writed_d = 1'b1;
          sym_valid_d   = 1'b1;
          sym_data_d    = word_head;
          state_d       = StShift;
        end
      end

      StShift: begin
        if (sym_fire) begin
          shreg_d    = shreg_next;
          cnt_d      = cnt_q - SCW'(1);
          sym_data_d = next_head;
          if (cnt_q == SCW'(1)) begin
            // Last symbol accepted: the word is complete even if start drops now.
            sym_valid_d  = 1'b0;
            word_count_d = word_count_q + CW'(1);
            state_d      = start ? StLoad : StIdle;
          end else if (!start) begin
            sym_valid_d = 1'b0;
            state_d     = StIdle;
          end
        end else if (!start) begin
          sym_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      default: begin
        sym_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase

    busy_d = (state_d == StLoad) || (state_d == StShift);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      shreg_q       <= '0;
      cnt_q         <= '0;
      sym_valid_q   <= 1'b0;
      sym_data_q    <= '0;
      word_writed_q <= 1'b0;
      word_count_q  <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      sym_valid_q   <= sym_valid_d;
      sym_data_q    <= sym_data_d;
      word_writed_q <= word_writed_d;
      word_count_q  <= word_count_d;
      busy_q        <= busy_d;
    end
  end

  assign word_writed = word_writed_q;
  assign sym_data    = sym_data_q;
  assign sym_valid   = sym_valid_q;
  assign busy        = busy_q;
  assign word_count  = word_count_q;

endmodule
